// File: rtl/arb_pkg.sv
// Shared definitions for the four-lane grant controller.
//   NLANES         : number of requesting lanes
//   ARB_FIXED/RR   : arbitration mode select values
//   arb_state_t    : controller state encoding (ST_IDLE / ST_BUSY)
package arb_pkg;

  localparam int NLANES = 4;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4-way priority picker.
//   cand    in  4 : candidate mask (already filtered by the caller)
//   base    in  2 : rotation base (last owner), used only in rotating mode
//   mode    in  1 : ARB_FIXED -> order 3,2,1,0; ARB_RR -> base-1, base-2, base-3, base
//   found   out 1 : at least one candidate set
//   win_idx out 2 : index of the winning candidate (0 when none)
module prio_pick4
  import arb_pkg::*;
(
  input  logic [3:0] cand,
  input  logic [1:0] base,
  input  logic       mode,
  output logic       found,
  output logic [1:0] win_idx
);

  logic [1:0] start_s;
  logic [1:0] idx_s;

  // Walk the search order from lowest to highest priority so the last hit wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 2'b00;
    idx_s   = 2'b00;
    // Fixed priority is the rotating search anchored at base 0 (3,2,1,0).
    start_s = (mode == ARB_RR) ? base : 2'b00;
    for (int k = 4; k >= 1; k--) begin
      idx_s   = start_s - 2'(k);
      found   = found | cand[idx_s];
      win_idx = cand[idx_s] ? idx_s : win_idx;
    end
  end

endmodule

// File: rtl/arb4_grant_ctrl.sv
// Four-requester grant controller with bounded hold time.
//   clk       in  1      : clock, rising edge
//   rst       in  1      : synchronous active-high reset
//   req       in  4      : level-sensitive request per lane
//   data_in   in  4*DW   : lane i at [i*DW +: DW]
//   gnt       out 4      : registered one-hot grant (or zero)
//   gnt_valid out 1      : registered OR of gnt
//   owner     out 2      : registered index of current/last owner
//   z         out DW     : data lane selected by gnt, zero when idle
module arb4_grant_ctrl
  import arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*DW-1:0]      data_in,
  output logic [3:0]           gnt,
  output logic                 gnt_valid,
  output logic [1:0]           owner,
  output logic [DW-1:0]        z
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam bit            HOLD_EN  = (MAX_HOLD > 0);
  localparam logic [CW-1:0] HOLD_LIM = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : CNT_ZERO;
  localparam logic          MODE     = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t      state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      gnt_s;
  logic [1:0]      owner_s;
  logic [3:0]      cand_s;
  logic            owner_req_s;
  logic            hold_hit_s;
  logic            pick_found_s;
  logic [1:0]      pick_idx_s;

  // While busy the owner is always masked out: if it released, its bit is
  // already low; if it hit the hold limit, it must not win again.
  assign cand_s      = (state_r == ST_BUSY) ? (req & ~(4'b0001 << owner)) : req;
  assign owner_req_s = req[owner];
  assign hold_hit_s  = HOLD_EN && (cnt_r >= HOLD_LIM);

  prio_pick4 u_pick (
    .cand    (cand_s),
    .base    (owner),
    .mode    (MODE),
    .found   (pick_found_s),
    .win_idx (pick_idx_s)
  );

  // Next-state, next-grant and hold-counter logic.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt;
    owner_s = owner;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_s = ST_BUSY;
          gnt_s   = 4'b0001 << pick_idx_s;
          owner_s = pick_idx_s;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_BUSY: begin
        if (!owner_req_s) begin
          if (pick_found_s) begin
            gnt_s   = 4'b0001 << pick_idx_s;
            owner_s = pick_idx_s;
            cnt_s   = CNT_ZERO;
          end else begin
            // Owner index is kept so rotating priority resumes after it.
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
            cnt_s   = CNT_ZERO;
          end
        end else if (!hold_hit_s) begin
          // Saturate so an unlimited hold never wraps into a false limit.
          cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        end else begin
          if (pick_found_s) begin
            gnt_s   = 4'b0001 << pick_idx_s;
            owner_s = pick_idx_s;
            cnt_s   = CNT_ZERO;
          end else begin
            // Nobody else waiting: owner starts a fresh hold window.
            cnt_s = CNT_ZERO;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, grant, owner and hold-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      owner     <= 2'b00;
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      gnt       <= gnt_s;
      gnt_valid <= |gnt_s;
      owner     <= owner_s;
      cnt_r     <= cnt_s;
    end
  end

  // Output mux: gnt is one-hot, so OR-ing the masked lanes selects the owner.
  always_comb begin
    z = {DW{1'b0}};
    for (int i = 0; i < NLANES; i++) begin
      z = z | ({DW{gnt[i]}} & data_in[i*DW +: DW]);
    end
  end

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Self-checking bench for arb4_grant_ctrl. Several instances with different
// mode/hold settings share clock, reset and data; each has its own req.
module tb_arb4_grant_ctrl;

  localparam int DW = 4;
  localparam int NI = 5;

  // Instance configuration: 0 fixed/4, 1 rr/1, 2 fixed/unlimited, 3 fixed/2, 4 rr/3.
  function automatic int hold_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 0;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int rr_of(input int g);
    return ((g == 1) || (g == 4)) ? 1 : 0;
  endfunction

  logic              clk;
  logic              rst;
  logic [4*DW-1:0]   data_in;
  logic [3:0]        req_a [NI];
  logic [3:0]        gnt_a [NI];
  logic              gv_a  [NI];
  logic [1:0]        own_a [NI];
  logic [DW-1:0]     z_a   [NI];

  int nchecks;
  int nfail;

  // Reference model: grant flag, owner, cycles held in the current grant.
  int m_granted [NI];
  int m_owner   [NI];
  int m_held    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    arb4_grant_ctrl #(
      .DW       (DW),
      .RR_MODE  (rr_of(g)),
      .MAX_HOLD (hold_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req_a[g]),
      .data_in   (data_in),
      .gnt       (gnt_a[g]),
      .gnt_valid (gv_a[g]),
      .owner     (own_a[g]),
      .z         (z_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Search base-1, base-2, base-3, base (mod 4); fixed mode uses base 0.
  function automatic int model_pick(input int base, input logic [3:0] cand);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (((base - k) % 4) + 4) % 4;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int g, input logic [3:0] r, input logic rs);
    int base;
    int w;
    int hl;
    logic [3:0] msk;
    base = (rr_of(g) != 0) ? m_owner[g] : 0;
    hl   = hold_of(g);
    if (rs) begin
      m_granted[g] = 0; m_owner[g] = 0; m_held[g] = 0;
    end else if (m_granted[g] == 0) begin
      w = model_pick(base, r);
      if (w >= 0) begin m_granted[g] = 1; m_owner[g] = w; m_held[g] = 1; end
    end else if (!r[m_owner[g]]) begin
      w = model_pick(base, r);
      if (w >= 0) begin m_owner[g] = w; m_held[g] = 1; end
      else m_granted[g] = 0;
    end else if ((hl == 0) || (m_held[g] < hl)) begin
      m_held[g] = m_held[g] + 1;
    end else begin
      msk = r;
      msk[m_owner[g]] = 1'b0;
      w = model_pick(base, msk);
      if (w >= 0) m_owner[g] = w;
      m_held[g] = 1;
    end
  endtask

  // One clock: model advances on the same sampled inputs, outputs read 1ns later.
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < NI; g++) model_step(g, req_a[g], rst);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int g = 0; g < NI; g++) req_a[g] = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 16'($urandom);
    for (int g = 0; g < NI; g++) req_a[g] = 4'b1111;
    tick();
    for (int g = 0; g < NI; g++) begin
      nchecks++;
      if ((gnt_a[g] !== 4'b0000) || (gv_a[g] !== 1'b0) || (own_a[g] !== 2'b00) || (z_a[g] !== 4'h0)) begin
        nfail++;
        $display("FAIL reset inst=%0d got gnt=%b gv=%b own=%0d z=%h exp all zero", g, gnt_a[g], gv_a[g], own_a[g], z_a[g]);
      end
    end
    apply_reset();
  endtask

  task automatic test_fixed_unlimited();
    apply_reset();
    req_a[2] = 4'b1111;
    nchecks++;
    if (gnt_a[2] !== 4'b0000) begin
      nfail++;
      $display("FAIL unl_pre_edge got=%b exp=0000", gnt_a[2]);
    end
    for (int i = 0; i < 12; i++) begin
      data_in = 16'($urandom);
      tick();
      nchecks++;
      if ((gnt_a[2] !== 4'b1000) || (z_a[2] !== data_in[15:12])) begin
        nfail++;
        $display("FAIL unl_hold cyc=%0d got gnt=%b z=%h exp gnt=1000 z=%h", i, gnt_a[2], z_a[2], data_in[15:12]);
      end
    end
  endtask

  task automatic test_fixed_hold4();
    logic [3:0] exp;
    apply_reset();
    req_a[0] = 4'b0101;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = (((i / 4) % 2) == 0) ? 4'b0100 : 4'b0001;
      nchecks++;
      if (gnt_a[0] !== exp) begin
        nfail++;
        $display("FAIL hold4_alt cyc=%0d got=%b exp=%b", i, gnt_a[0], exp);
      end
    end
  endtask

  task automatic test_rr_hold1();
    logic [3:0] seq [5];
    seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    apply_reset();
    req_a[1] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchecks++;
      if (gnt_a[1] !== seq[i]) begin
        nfail++;
        $display("FAIL rr_seq step=%0d got=%b exp=%b", i, gnt_a[1], seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_a[0] = 4'b0100;
    tick();
    req_a[0] = 4'b1100;
    tick();
    nchecks++;
    if (gnt_a[0] !== 4'b0100) begin
      nfail++;
      $display("FAIL no_preempt got=%b exp=0100", gnt_a[0]);
    end
    req_a[0] = 4'b0101;
    tick();
    req_a[0] = 4'b0001;
    tick();
    nchecks++;
    if ((gnt_a[0] !== 4'b0001) || (gv_a[0] !== 1'b1)) begin
      nfail++;
      $display("FAIL handover got gnt=%b gv=%b exp gnt=0001 gv=1", gnt_a[0], gv_a[0]);
    end
    req_a[0] = 4'b0100;
    tick();
    tick();
    req_a[0] = 4'b0000;
    tick();
    nchecks++;
    if ((gnt_a[0] !== 4'b0000) || (gv_a[0] !== 1'b0) || (own_a[0] !== 2'd2)) begin
      nfail++;
      $display("FAIL release_idle got gnt=%b gv=%b own=%0d exp gnt=0000 gv=0 own=2", gnt_a[0], gv_a[0], own_a[0]);
    end
  endtask

  task automatic test_single_hold2();
    apply_reset();
    req_a[3] = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      tick();
      nchecks++;
      if ((gnt_a[3] !== 4'b0010) || (gv_a[3] !== 1'b1)) begin
        nfail++;
        $display("FAIL lone_hold cyc=%0d got gnt=%b gv=%b exp gnt=0010 gv=1", i, gnt_a[3], gv_a[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_in = 16'hA5C3;
    req_a[2] = 4'b1111;
    tick();
    tick();
    nchecks++;
    if ((gnt_a[2] !== 4'b1000) || (own_a[2] !== 2'd3) || (z_a[2] !== 4'hA)) begin
      nfail++;
      $display("FAIL mid_busy got gnt=%b own=%0d z=%h exp gnt=1000 own=3 z=a", gnt_a[2], own_a[2], z_a[2]);
    end
    rst = 1'b1;
    tick();
    nchecks++;
    if ((gnt_a[2] !== 4'b0000) || (own_a[2] !== 2'd0) || (gv_a[2] !== 1'b0) || (z_a[2] !== 4'h0)) begin
      nfail++;
      $display("FAIL mid_reset got gnt=%b own=%0d gv=%b z=%h exp zeros", gnt_a[2], own_a[2], gv_a[2], z_a[2]);
    end
    rst = 1'b0;
    req_a[2] = 4'b0001;
    tick();
    nchecks++;
    if ((gnt_a[2] !== 4'b0001) || (z_a[2] !== 4'h3)) begin
      nfail++;
      $display("FAIL post_reset got gnt=%b z=%h exp gnt=0001 z=3", gnt_a[2], z_a[2]);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [3:0] one;
    logic [DW-1:0] ez;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < NI; g++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 3) == 0) req_a[g][b] = ~req_a[g][b];
        end
      end
      data_in = 16'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      tick();
      for (int g = 0; g < NI; g++) begin
        one = 4'b0001;
        eg  = (m_granted[g] != 0) ? (one << m_owner[g]) : 4'b0000;
        ez  = (m_granted[g] != 0) ? data_in[m_owner[g]*DW +: DW] : 4'h0;
        nchecks++;
        if ((gnt_a[g] !== eg) || (gv_a[g] !== (m_granted[g] != 0)) ||
            (own_a[g] !== 2'(m_owner[g])) || (z_a[g] !== ez)) begin
          nfail++;
          $display("FAIL rand inst=%0d cyc=%0d got gnt=%b gv=%b own=%0d z=%h exp gnt=%b gv=%0d own=%0d z=%h",
                   g, c, gnt_a[g], gv_a[g], own_a[g], z_a[g], eg, m_granted[g], m_owner[g], ez);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    nchecks = 0;
    nfail   = 0;
    rst     = 1'b1;
    data_in = 16'h0000;
    for (int g = 0; g < NI; g++) begin
      req_a[g] = 4'b0000;
      m_granted[g] = 0; m_owner[g] = 0; m_held[g] = 0;
    end
    test_reset();
    test_fixed_unlimited();
    test_fixed_hold4();
    test_rr_hold1();
    test_back_to_back();
    test_single_hold2();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
